// File: rtl/power_grant_pkg.sv
// Shared types for the power grant arbiter.
//   state_t : one-hot FSM state encoding, also driven out on the state port.
package power_grant_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_GNT   = 4'b0010,
        ST_SLEEP = 4'b0100,
        ST_WAKE  = 4'b1000
    } state_t;

endpackage

// File: rtl/power_grant_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Searches req upward from rr_ptr, wrapping at N_CH, and returns the first set bit.
//   req    : per-channel request vector
//   rr_ptr : channel index where the search starts
//   pick   : one-hot of the chosen channel (all-zero when nothing requests)
//   idx    : index of the chosen channel (0 when nothing requests)
//   any    : at least one request is set
module rr_pick #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] rr_ptr,
    output logic [N_CH-1:0]         pick,
    output logic [$clog2(N_CH)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(N_CH);

    int            cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        pick     = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand     = (int'(rr_ptr) + k) % N_CH;
            cand_idx = IW'(cand);
            if (!any && req[cand_idx]) begin
                any           = 1'b1;
                idx           = cand_idx;
                pick[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/power_grant_arbiter.sv
// Round-robin grant arbiter with bounded hold time, idle-timeout sleep and a
// timed wake sequence. Sits between requesting power domains and the
// power-switch controller.
//   clock     : single clock, rising edge
//   reset     : synchronous, active-high
//   req       : per-channel level request
//   gnt       : registered one-hot grant (or zero)
//   gnt_id    : index of the granted channel, meaningful while gnt_valid
//   gnt_valid : |gnt
//   state     : one-hot FSM state
//   sleep_en  : power-down request, high only in SLEEP
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; pick next requester, or count toward sleep timeout
// GNT   | one channel holds gnt; released on drop or hold-limit pre-empt
// SLEEP | sleep_en asserted; any request starts the wake sequence
// WAKE  | fixed-length power-up delay, requests ignored, then IDLE
module power_grant_arbiter
    import power_grant_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int HOLD_MAX     = 16,
    parameter int SLEEP_CYCLES = 8,
    parameter int WAKE_CYCLES  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         req,
    output logic [N_CH-1:0]         gnt,
    output logic [$clog2(N_CH)-1:0] gnt_id,
    output logic                    gnt_valid,
    output logic [3:0]              state,
    output logic                    sleep_en
);

    localparam int IW      = $clog2(N_CH);
    localparam int HOLD_W  = $clog2(HOLD_MAX + 1);
    localparam int IDLE_W  = $clog2(SLEEP_CYCLES + 1);
    localparam int WAKE_W  = $clog2(WAKE_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SLEEP_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [IW-1:0]     CH_LAST   = IW'(N_CH - 1);

    state_t            state_q;
    logic [IW-1:0]     rr_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [WAKE_W-1:0] wake_cnt;

    logic [N_CH-1:0]   pick;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              holder_req;
    logic              others_req;

    rr_pick #(
        .N_CH (N_CH)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // gnt is one-hot while in GNT, so masking with it selects the holder
    // without indexing req by gnt_id.
    assign holder_req = |(req & gnt);
    assign others_req = |(req & ~gnt);
    assign state      = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            sleep_en  <= 1'b0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            idle_cnt  <= '0;
            wake_cnt  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q   <= ST_GNT;
                        gnt       <= pick;
                        gnt_id    <= pick_idx;
                        gnt_valid <= 1'b1;
                        rr_ptr    <= (pick_idx == CH_LAST) ? '0 : pick_idx + 1'b1;
                        hold_cnt  <= '0;
                        idle_cnt  <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state_q  <= ST_SLEEP;
                        sleep_en <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_GNT: begin
                    if (!holder_req || (hold_cnt == HOLD_LAST && others_req)) begin
                        state_q   <= ST_IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_SLEEP: begin
                    if (|req) begin
                        state_q  <= ST_WAKE;
                        sleep_en <= 1'b0;
                        wake_cnt <= '0;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state_q  <= ST_IDLE;
                        idle_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    sleep_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_grant_arbiter.sv
// Self-checking bench for power_grant_arbiter: vector table, directed
// multi-cycle sequences, and randomized traffic against a cycle-count model.
module tb_power_grant_arbiter;

    localparam int N_CH         = 4;
    localparam int HOLD_MAX     = 16;
    localparam int SLEEP_CYCLES = 8;
    localparam int WAKE_CYCLES  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_GNT   = 1;
    localparam int M_SLEEP = 2;
    localparam int M_WAKE  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic [3:0] state;
    logic       sleep_en;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;

    // Reference model: counts of cycles spent in each condition.
    int m_mode   = M_IDLE;
    int m_holder = 0;
    int m_ptr    = 0;
    int m_held   = 0;
    int m_idle   = 0;
    int m_wake   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] state;
        logic       sleep;
    } vec_t;

    vec_t tbl[12];

    power_grant_arbiter #(
        .N_CH         (N_CH),
        .HOLD_MAX     (HOLD_MAX),
        .SLEEP_CYCLES (SLEEP_CYCLES),
        .WAKE_CYCLES  (WAKE_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .state     (state),
        .sleep_en  (sleep_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] others;
        if (reset) begin
            m_mode   = M_IDLE;
            m_holder = 0;
            m_ptr    = 0;
            m_held   = 0;
            m_idle   = 0;
            m_wake   = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (req != 4'b0000) begin
                        for (int k = 0; k < N_CH; k++) begin
                            int c;
                            c = (m_ptr + k) % N_CH;
                            if (req[c]) begin
                                m_holder = c;
                                break;
                            end
                        end
                        m_ptr  = (m_holder + 1) % N_CH;
                        m_held = 1;
                        m_mode = M_GNT;
                    end else begin
                        m_idle++;
                        if (m_idle >= SLEEP_CYCLES) m_mode = M_SLEEP;
                    end
                end
                M_GNT: begin
                    others = req;
                    others[m_holder] = 1'b0;
                    if (!req[m_holder] || (m_held >= HOLD_MAX && others != 4'b0000)) begin
                        m_mode = M_IDLE;
                        m_idle = 0;
                    end else begin
                        m_held++;
                    end
                end
                M_SLEEP: begin
                    if (req != 4'b0000) begin
                        m_mode = M_WAKE;
                        m_wake = 0;
                    end
                end
                default: begin
                    m_wake++;
                    if (m_wake >= WAKE_CYCLES) begin
                        m_mode = M_IDLE;
                        m_idle = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_model();
        logic [3:0] want_gnt;
        want_gnt = (m_mode == M_GNT) ? (4'b0001 << m_holder) : 4'b0000;
        check("model_gnt", gnt, want_gnt);
        check("model_state", state, 4'b0001 << m_mode);
        check("model_sleep_en", sleep_en, m_mode == M_SLEEP);
        check("model_gnt_valid", gnt_valid, want_gnt != 4'b0000);
        if (m_mode == M_GNT) check("model_gnt_id", gnt_id, m_holder);
        check("gnt_onehot0", $onehot0(gnt), 1);
        check("gnt_valid_or", gnt_valid, |gnt);
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_on) check_model();
    end

    // Reset for one edge, then release with the given request already applied.
    task automatic do_reset(input logic [3:0] r_after);
        @(negedge clock);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        req   = r_after;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int rise;
        logic [3:0] want;

        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 4'b0010, 1'b0};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 4'b0010, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[4]  = '{1'b0, 4'b0011, 4'b0001, 4'b0010, 1'b0};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[6]  = '{1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[8]  = '{1'b0, 4'b1000, 4'b1000, 4'b0010, 1'b0};
        tbl[9]  = '{1'b1, 4'b1000, 4'b0000, 4'b0001, 1'b0};
        tbl[10] = '{1'b0, 4'b1010, 4'b0010, 4'b0010, 1'b0};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0};

        @(posedge clock);
        #1;
        chk_on = 1'b1;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            reset = tbl[i].rst;
            req   = tbl[i].req;
            tick();
            check("tbl_gnt", gnt, tbl[i].gnt);
            check("tbl_state", state, tbl[i].state);
            check("tbl_sleep_en", sleep_en, tbl[i].sleep);
        end

        // Sleep entry timing from reset release
        do_reset(4'b0000);
        rise = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("idle_gnt_zero", gnt, 4'b0000);
            if (sleep_en && rise < 0) rise = e;
        end
        check("sleep_rise_edge", rise, SLEEP_CYCLES);
        check("sleep_state", state, 4'b0100);

        // Two steady competitors alternate with hold-limit pre-emption
        do_reset(4'b0101);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i % (HOLD_MAX + 1) == HOLD_MAX) want = 4'b0000;
            else if ((i / (HOLD_MAX + 1)) % 2 == 0) want = 4'b0001;
            else want = 4'b0100;
            check("rr_alt_gnt", gnt, want);
            if (want != 4'b0000)
                check("rr_alt_gnt_id", gnt_id, (want == 4'b0001) ? 0 : 2);
        end

        // Lone requester is never pre-empted
        do_reset(4'b0010);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("lone_gnt", gnt, 4'b0010);
        end
        @(negedge clock);
        req = 4'b0000;
        tick();
        check("lone_release", gnt, 4'b0000);

        // Wake sequence from SLEEP
        do_reset(4'b0000);
        repeat (10) tick();
        check("wake_pre_sleep", sleep_en, 1'b1);
        @(negedge clock);
        req = 4'b1000;
        tick();
        check("wake_sleep_fall", sleep_en, 1'b0);
        check("wake_state_t", state, 4'b1000);
        tick();
        check("wake_state_t1", state, 4'b1000);
        tick();
        check("wake_state_t2", state, 4'b0001);
        check("wake_gnt_t2", gnt, 4'b0000);
        tick();
        check("wake_gnt_t3", gnt, 4'b1000);

        // Reset mid-grant
        do_reset(4'b0100);
        tick();
        check("rst_gnt_pre", gnt, 4'b0100);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rst_gnt_gnt", gnt, 4'b0000);
        check("rst_gnt_state", state, 4'b0001);
        check("rst_gnt_valid", gnt_valid, 1'b0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_gnt_sleep", sleep_en, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b0110;
        tick();
        check("rst_gnt_regrant", gnt, 4'b0010);

        // Reset mid-wake
        do_reset(4'b0000);
        repeat (10) tick();
        @(negedge clock);
        req = 4'b0001;
        tick();
        check("rst_wake_pre", state, 4'b1000);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rst_wake_state", state, 4'b0001);
        check("rst_wake_sleep", sleep_en, 1'b0);
        check("rst_wake_gnt", gnt, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b1001;
        tick();
        check("rst_wake_regrant", gnt, 4'b0001);

        // Randomized traffic, checked every cycle against the model
        do_reset(4'b0000);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) == 0) req = 4'b0000;
                else req = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/power_grant_arbiter.md
# power_grant_arbiter

Parametrised successor to the single-pair grant decoder. Arbitrates `N_CH` request lines round-robin and issues a registered one-hot grant. Bounds grant hold time and pre-empts the holder when others are waiting. Adds an idle-timeout sleep state with a timed wake sequence, so the block sits between the requesting power domains and the power-switch controller.

## Interface
Parameters:
- `N_CH`, 4, number of requesting channels (≥2)
- `HOLD_MAX`, 16, max consecutive grant cycles before pre-emption (≥1)
- `SLEEP_CYCLES`, 8, consecutive request-free IDLE cycles before entering SLEEP (≥1)
- `WAKE_CYCLES`, 2, cycles spent in WAKE before returning to IDLE (≥1)

Ports:
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  `N_CH`  per-channel request, level; held while channel wants the grant
- `gnt`  out  `N_CH`  registered one-hot grant, or all-zero
- `gnt_id`  out  `$clog2(N_CH)`  index of granted channel; valid only when `gnt_valid`
- `gnt_valid`  out  1  equals `|gnt`
- `state`  out  4  one-hot current state
- `sleep_en`  out  1  power-down request to switch controller; high exactly in SLEEP

## Operation
- States, one-hot: IDLE=4'b0001, GNT=4'b0010, SLEEP=4'b0100, WAKE=4'b1000.
- Reset values: `state`=IDLE, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `sleep_en`=0. Round-robin pointer `rr_ptr`=0, `hold_cnt`=0, `idle_cnt`=0, `wake_cnt`=0.
- IDLE:
  - Any `req` → pick the first set bit searching from `rr_ptr` upward with wrap → GNT.
  - On that edge: `gnt` gets the one-hot pick, `gnt_id` gets its index, `rr_ptr` gets (index+1) mod `N_CH`, `hold_cnt` gets 0, `idle_cnt` gets 0.
  - No `req` → `idle_cnt`++. When `idle_cnt`==`SLEEP_CYCLES`-1 with no `req` → SLEEP.
- GNT, holder g:
  - `req[g]` low → `gnt` cleared, go IDLE.
  - Else if `hold_cnt`==`HOLD_MAX`-1 and any other `req` set → pre-empt: `gnt` cleared, go IDLE.
  - Else `hold_cnt`++, saturating at `HOLD_MAX`-1. The holder keeps the grant indefinitely while it is the only requester.
- SLEEP: `sleep_en`=1. Any `req` → WAKE with `wake_cnt`=0.
- WAKE: `sleep_en`=0; `req` is ignored. `wake_cnt`++. When `wake_cnt`==`WAKE_CYCLES`-1 → IDLE with `idle_cnt`=0.
- An invalid or non-one-hot `state` value → IDLE with outputs cleared.
- Counter widths: `$clog2(HOLD_MAX+1)`, `$clog2(SLEEP_CYCLES+1)`, `$clog2(WAKE_CYCLES+1)`. No counter wraps.

## Timing
- `req` seen in IDLE at edge t → `gnt` high after edge t (visible cycle t+1).
- Release: `req[g]` low sampled at edge t → `gnt` low after t. Earliest re-grant is after edge t+1; there is one dead cycle between grants.
- Pre-emption: holder granted after edge t0 and continuously requesting with a competitor → `gnt` drops after edge t0+`HOLD_MAX`. The competitor is granted one edge later.
- Sleep entry: last request-free IDLE cycle → `sleep_en` high `SLEEP_CYCLES` edges after entering IDLE with `req`=0.
- Wake: `req` at edge t in SLEEP → WAKE after t, IDLE after t+`WAKE_CYCLES`, `gnt` after t+`WAKE_CYCLES`+1.
- Simultaneous requests: round-robin order from `rr_ptr` decides; the pointer advances only on an issued grant.
- `reset` overrides everything at the next edge, including mid-grant and mid-wake. `gnt` and `sleep_en` are 0 after that edge.

## Structure
- Package `power_grant_pkg`: `typedef enum logic [3:0]` for the state and its one-hot encodings.
- Sub-module `rr_pick`: combinational round-robin priority picker, parametrised by `N_CH`.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot pick, index, any.
- Top: state register, counters, output registers.

## Test plan
- Reset, then `req`=4'b0000 for 20 cycles → `gnt`=0 and `sleep_en` rises exactly 8 edges after reset release. `state`=4'b0100.
- `req`=4'b0101 held constantly → grants ch0 for 16 cycles, dead cycle, ch2 for 16, dead cycle, ch0. `gnt_id` alternates 0/2.
- `req`=4'b0010 alone for 40 cycles → `gnt`=4'b0010 throughout, with no pre-emption. Drop `req` → `gnt`=0 next edge.
- From SLEEP, pulse `req`=4'b1000 and hold → WAKE for 2 cycles, then `gnt`=4'b1000 at edge t+3. `sleep_en` falls after edge t.
- Assert `reset` while `gnt`=4'b0100 and during WAKE → all outputs return to reset values after one edge. First grant after release goes to lowest requesting index (`rr_ptr`=0).
- Check `gnt` is always one-hot or zero, and `gnt_valid`==|`gnt`, on every cycle across all scenarios.
